// File: rtl/tone_pkg.sv
// Shared types and the 100 MHz note period table for the tone detector.
package tone_pkg;

  localparam int TONE_CNT_W = 20;

  typedef logic [15:0][31:0] note_tab_t;

  // Index 0 is C4. Zero entries are never matched.
  localparam note_tab_t NOTE_PERIOD = {
    {8{32'd0}},
    32'd190840, 32'd202478, 32'd227273, 32'd255102,
    32'd286352, 32'd303370, 32'd340530, 32'd381679
  };

  typedef enum logic [1:0] {ARM, MEASURE, SEARCH} state_t;

endpackage

// File: rtl/tone_sync_edge.sv
// Three-flop synchronizer for an asynchronous input, with a rising-edge strobe.
module tone_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_detector.sv
// Measures a square-wave period in clk cycles and classifies it against a note table.
// Define TONE_DETECTOR_AVG_EN to average four captured periods per classification.
module tone_detector
  import tone_pkg::*;
#(
  parameter int        CNT_W      = TONE_CNT_W,
  parameter int        MAX_PERIOD = 1048575,
  parameter int        NUM_NOTES  = 8,
  parameter int        TOL_SHIFT  = 5,
  parameter note_tab_t NOTE_TABLE = NOTE_PERIOD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sq_in,
  output logic [7:0]       note_code,
  output logic [CNT_W-1:0] period,
  output logic             note_valid,
  output logic             tone_present
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(MAX_PERIOD);

  state_t           state, state_nxt;
  logic             rise;
  logic [CNT_W-1:0] cnt, meas, refv;
  logic [CNT_W:0]   dif;
  logic [3:0]       idx;
  logic             hit, last, cap_done;

  tone_sync_edge u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sq_in),
    .rise (rise)
  );

`ifdef TONE_DETECTOR_AVG_EN
  logic [CNT_W+1:0] acc, acc_sum;
  logic [1:0]       acnt;
  assign acc_sum  = acc + {2'b00, cnt};
  assign cap_done = (acnt == 2'd3);
`else
  assign cap_done = 1'b1;
`endif

  assign refv = NOTE_TABLE[idx][CNT_W-1:0];

  // Difference kept one bit wider so it never wraps.
  always_comb begin
    dif = ({1'b0, meas} >= {1'b0, refv}) ? ({1'b0, meas} - {1'b0, refv})
                                         : ({1'b0, refv} - {1'b0, meas});
    hit  = (refv != '0) && (dif <= ({1'b0, refv} >> TOL_SHIFT));
    last = (idx == 4'(NUM_NOTES - 1));
    state_nxt = state;
    case (state)
      ARM:     if (rise) state_nxt = MEASURE;
      MEASURE: begin
        if (rise) begin
          if (cap_done) state_nxt = SEARCH;
        end else if (cnt == CMAX) begin
          state_nxt = ARM;
        end
      end
      SEARCH:  if (hit || last) state_nxt = MEASURE;
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARM;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (rise)         cnt <= CNT_W'(1);
    else if (cnt != CMAX)  cnt <= cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas         <= '0;
      idx          <= '0;
      note_code    <= '0;
      period       <= '0;
      note_valid   <= 1'b0;
      tone_present <= 1'b0;
`ifdef TONE_DETECTOR_AVG_EN
      acc          <= '0;
      acnt         <= '0;
`endif
    end else begin
      note_valid <= 1'b0;
      case (state)
        MEASURE: begin
          if (rise) begin
`ifdef TONE_DETECTOR_AVG_EN
            if (cap_done) begin
              meas <= acc_sum[CNT_W+1:2];
              idx  <= '0;
              acc  <= '0;
              acnt <= '0;
            end else begin
              acc  <= acc_sum;
              acnt <= acnt + 2'd1;
            end
`else
            meas <= cnt;
            idx  <= '0;
`endif
          end else if (cnt == CMAX) begin
            note_code    <= '0;
            period       <= '0;
            tone_present <= 1'b0;
            note_valid   <= 1'b1;
`ifdef TONE_DETECTOR_AVG_EN
            acc          <= '0;
            acnt         <= '0;
`endif
          end
        end
        SEARCH: begin
`ifdef TONE_DETECTOR_AVG_EN
          // A rise during the search is discarded, so the partial average is too.
          if (rise) begin
            acc  <= '0;
            acnt <= '0;
          end
`endif
          if (hit) begin
            note_code    <= 8'(idx) + 8'd1;
            period       <= meas;
            tone_present <= 1'b1;
            note_valid   <= 1'b1;
          end else if (last) begin
            note_code    <= '0;
            period       <= meas;
            tone_present <= 1'b1;
            note_valid   <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector using a scaled-down note table and timeout.
module tb_tone_detector;
  import tone_pkg::*;

  localparam int MAXP = 1000;
  localparam int SYNC_LAT = 3;
  localparam note_tab_t TAB = {
    {8{32'd0}},
    32'd191, 32'd202, 32'd227, 32'd255, 32'd286, 32'd303, 32'd341, 32'd382
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sq_in = 1'b0;
  logic [7:0]  note_code;
  logic [19:0] period;
  logic        note_valid;
  logic        tone_present;

  typedef struct packed {
    logic [7:0]  code;
    logic [19:0] per;
    logic        tp;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_vld_cyc = 0;
  int   last_rise = 0;
  logic vld_d = 1'b0;

  tone_detector #(
    .CNT_W(20), .MAX_PERIOD(MAXP), .NUM_NOTES(8), .TOL_SHIFT(5), .NOTE_TABLE(TAB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sq_in(sq_in), .note_code(note_code),
    .period(period), .note_valid(note_valid), .tone_present(tone_present)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every note_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (note_valid) begin
      exp_t e;
      n_cmp++;
      if (vld_d) begin
        n_bad++;
        $display("FAIL valid_twice: got 2 consecutive pulses want 1 at cyc %0d", cyc);
      end
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_valid: got pulse code=%0d period=%0d want none at cyc %0d",
                 note_code, period, cyc);
      end else begin
        e = q.pop_front();
        n_cmp++;
        if (note_code !== e.code) begin
          n_bad++;
          $display("FAIL note_code: got %0d want %0d", note_code, e.code);
        end
        n_cmp++;
        if (period !== e.per) begin
          n_bad++;
          $display("FAIL period: got %0d want %0d", period, e.per);
        end
        n_cmp++;
        if (tone_present !== e.tp) begin
          n_bad++;
          $display("FAIL tone_present: got %0b want %0b", tone_present, e.tp);
        end
      end
      last_vld_cyc = cyc;
    end
    vld_d = note_valid;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish before 900us");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int code, input int per, input bit tp);
    exp_t e;
    e.code = 8'(code);
    e.per  = 20'(per);
    e.tp   = tp;
    q.push_back(e);
  endtask

  // n rises spaced p apart; the first rise closes a period of pp unless the detector is armed.
  task automatic tone(input int p, input int n, input bit arm, input int code,
                      input int pcode, input int pp);
    for (int k = 0; k < n; k++) begin
      sq_in = 1'b1;
      last_rise = cyc;
      if (k > 0)     push(code, p, 1'b1);
      else if (!arm) push(pcode, pp, 1'b1);
      step(p / 2);
      sq_in = 1'b0;
      step(p - p / 2);
    end
  endtask

  task automatic drain(input string name, input int bound);
    int t = 0;
    while (q.size() != 0 && t < bound) begin
      step(1);
      t++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d pending want 0 pending", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    n_cmp++; if (note_code !== 8'd0)    begin n_bad++; $display("FAIL rst_code: got %0d want 0", note_code); end
    n_cmp++; if (period !== 20'd0)      begin n_bad++; $display("FAIL rst_period: got %0d want 0", period); end
    n_cmp++; if (note_valid !== 1'b0)   begin n_bad++; $display("FAIL rst_valid: got %0b want 0", note_valid); end
    n_cmp++; if (tone_present !== 1'b0) begin n_bad++; $display("FAIL rst_present: got %0b want 0", tone_present); end
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_a4();
    tone(227, 3, 1'b1, 6, 0, 0);
    drain("a4_drain", 20);
    n_cmp++;
    if (tone_present !== 1'b1) begin n_bad++; $display("FAIL a4_present: got %0b want 1", tone_present); end
  endtask

  task automatic test_tolerance();
    tone(234, 3, 1'b0, 6, 6, 227);
    tone(236, 3, 1'b0, 0, 6, 234);
    drain("tol_drain", 20);
  endtask

  task automatic test_switch();
    tone(382, 3, 1'b0, 1, 0, 236);
    tone(191, 3, 1'b0, 8, 1, 382);
    drain("switch_drain", 20);
  endtask

  task automatic test_rst_search();
    sq_in = 1'b1;   // closes a 191-cycle period; search walks to the last entry
    step(SYNC_LAT + 2);
    rst_n = 1'b0;
    sq_in = 1'b0;
    #2;
    n_cmp++; if (note_code !== 8'd0)    begin n_bad++; $display("FAIL rs_code: got %0d want 0", note_code); end
    n_cmp++; if (period !== 20'd0)      begin n_bad++; $display("FAIL rs_period: got %0d want 0", period); end
    n_cmp++; if (tone_present !== 1'b0) begin n_bad++; $display("FAIL rs_present: got %0b want 0", tone_present); end
    step(20);
    rst_n = 1'b1;
    step(3);
    tone(227, 3, 1'b1, 6, 0, 0);
    drain("rs_drain", 20);
  endtask

  task automatic test_timeout();
    push(0, 0, 1'b0);
    drain("timeout_drain", MAXP + 50);
    n_cmp++;
    if (last_vld_cyc - last_rise !== MAXP + SYNC_LAT) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d want %0d", last_vld_cyc - last_rise, MAXP + SYNC_LAT);
    end
    step(3 * MAXP);
    n_cmp++;
    if (tone_present !== 1'b0) begin n_bad++; $display("FAIL idle_present: got %0b want 0", tone_present); end
  endtask

`ifdef TONE_DETECTOR_AVG_EN
  task automatic test_avg();
    int ps [5] = '{255, 256, 255, 256, 255};
    for (int k = 0; k < 5; k++) begin
      sq_in = 1'b1;
      last_rise = cyc;
      if (k == 4) push(5, 255, 1'b1);   // (255+256+255+256)/4
      step(ps[k] / 2);
      sq_in = 1'b0;
      step(ps[k] - ps[k] / 2);
    end
    drain("avg_drain", 20);
  endtask
`endif

  initial begin
    test_reset();
`ifdef TONE_DETECTOR_AVG_EN
    test_avg();
`else
    test_a4();
    test_tolerance();
    test_switch();
    test_rst_search();
`endif
    test_timeout();
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL final_queue: got %0d want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
